// File: rtl/crc_stream_engine.sv
// Streaming CRC generator/checker: byte-serial unrolled LFSR over DATA_W/8 lanes per beat,
// framed with sop/eop, partial last beat, registered CRC and residue check with valid/ready.
module crc_stream_engine #(
  parameter int unsigned       CRC_W   = 16,
  parameter int unsigned       DATA_W  = 8,
  parameter logic [CRC_W-1:0]  POLY    = 16'h8005,
  parameter logic [CRC_W-1:0]  INIT    = 16'hFFFF,
  parameter bit                REFIN   = 1'b1,
  parameter bit                REFOUT  = 1'b1,
  parameter logic [CRC_W-1:0]  XOR_OUT = 16'hFFFF,
  parameter logic [CRC_W-1:0]  RESIDUE = 16'h800D
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_data,
  input  logic                        in_sop,
  input  logic                        in_eop,
  input  logic [$clog2(DATA_W/8):0]   in_bytes,
  output logic                        crc_valid,
  input  logic                        crc_ready,
  output logic [CRC_W-1:0]            crc_out,
  output logic                        crc_ok
);

  localparam int unsigned NB = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  function automatic logic [CRC_W-1:0] rev_crc(input logic [CRC_W-1:0] c);
    logic [CRC_W-1:0] r;
    for (int i = 0; i < int'(CRC_W); i++) r[i] = c[int'(CRC_W)-1-i];
    return r;
  endfunction

  // One byte through the MSB-first LFSR; reflected-input CRCs feed the byte LSB first.
  function automatic logic [CRC_W-1:0] crc_byte(input logic [CRC_W-1:0] c, input logic [7:0] d);
    logic [7:0]       b;
    logic [CRC_W-1:0] r;
    logic             fb;
    b = REFIN ? rev8(d) : d;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[CRC_W-1] ^ b[i];
      r  = {r[CRC_W-2:0], 1'b0};
      if (fb) r = r ^ POLY;
    end
    return r;
  endfunction

  // Lanes at or beyond nbytes pass the register through untouched.
  function automatic logic [CRC_W-1:0] crc_beat(input logic [CRC_W-1:0] seed,
                                                input logic [DATA_W-1:0] data,
                                                input int unsigned nbytes);
    logic [CRC_W-1:0] r;
    r = seed;
    for (int unsigned k = 0; k < NB; k++) begin
      if (k < nbytes) r = crc_byte(r, data[8*k +: 8]);
    end
    return r;
  endfunction

  state_t           state_q, state_d;
  logic [CRC_W-1:0] crc_q, crc_d;
  logic [CRC_W-1:0] crc_out_q, crc_out_d;
  logic             crc_ok_q, crc_ok_d;
  logic             crc_valid_q, crc_valid_d;

  logic             accept_c;
  logic             pop_c;
  int unsigned      nb_lanes_c;
  logic [CRC_W-1:0] seed_c;
  logic [CRC_W-1:0] beat_crc_c;

  assign in_ready = rst || (state_q != HOLD) || crc_ready;
  assign accept_c = in_valid && in_ready;
  assign pop_c    = crc_valid_q && crc_ready;

  // Lanes consumed this beat: all of them unless eop narrows it; 0 means a full beat.
  always_comb begin
    nb_lanes_c = NB;
    if (in_eop && (in_bytes != '0) && (32'(in_bytes) < NB)) nb_lanes_c = 32'(in_bytes);
  end

  // Anything but a continuing RUN frame starts from INIT.
  assign seed_c     = (in_sop || (state_q != RUN)) ? INIT : crc_q;
  assign beat_crc_c = crc_beat(seed_c, in_data, nb_lanes_c);

  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    crc_out_d = crc_out_q;
    crc_ok_d  = crc_ok_q;

    if (pop_c) state_d = IDLE;

    if (accept_c) begin
      if (in_eop) begin
        state_d   = HOLD;
        crc_d     = INIT;
        crc_out_d = (REFOUT ? rev_crc(beat_crc_c) : beat_crc_c) ^ XOR_OUT;
        crc_ok_d  = (beat_crc_c == RESIDUE);
      end else begin
        state_d = RUN;
        crc_d   = beat_crc_c;
      end
    end

    crc_valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      crc_q       <= INIT;
      crc_out_q   <= '0;
      crc_ok_q    <= 1'b0;
      crc_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      crc_out_q   <= crc_out_d;
      crc_ok_q    <= crc_ok_d;
      crc_valid_q <= crc_valid_d;
    end
  end

  assign crc_valid = crc_valid_q;
  assign crc_out   = crc_out_q;
  assign crc_ok    = crc_ok_q;

endmodule

// File: tb/tb_crc_stream_engine.sv
// Bench for crc_stream_engine: CRC-16/USB byte-wide and CRC-32 word-wide instances,
// table vectors, directed corner sequences and randomized frames against a bit-stream model.
module tb_crc_stream_engine;

  typedef logic [7:0] bq_t[$];
  typedef struct packed { logic [31:0] crc; logic ok; } exp_t;
  typedef struct {
    bit v; bit sop; bit eop; logic [7:0] d; bit cr;
    bit exp_cv; logic [15:0] exp_co; bit exp_ok;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        v16, rdy16, sop16, eop16, cv16, cr16, ok16;
  logic [7:0]  d16;
  logic [0:0]  nb16;
  logic [15:0] co16;

  logic        v32, rdy32, sop32, eop32, cv32, cr32, ok32;
  logic [31:0] d32;
  logic [2:0]  nb32;
  logic [31:0] co32;

  int n_vec = 0;
  int n_err = 0;

  crc_stream_engine u_dut16 (
    .clk(clk), .rst(rst), .in_valid(v16), .in_ready(rdy16), .in_data(d16),
    .in_sop(sop16), .in_eop(eop16), .in_bytes(nb16), .crc_valid(cv16),
    .crc_ready(cr16), .crc_out(co16), .crc_ok(ok16)
  );

  crc_stream_engine #(
    .CRC_W(32), .DATA_W(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF),
    .REFIN(1'b1), .REFOUT(1'b1), .XOR_OUT(32'hFFFFFFFF), .RESIDUE(32'hC704DD7B)
  ) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(v32), .in_ready(rdy32), .in_data(d32),
    .in_sop(sop32), .in_eop(eop32), .in_bytes(nb32), .crc_valid(cv32),
    .crc_ready(cr32), .crc_out(co32), .crc_ok(ok32)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] reflect(input logic [31:0] x, input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < w; i++) r[w-1-i] = x[i];
    return r;
  endfunction

  // Polynomial division of the message seen as a serial bit stream in transmission order.
  function automatic logic [31:0] model_reg(input bq_t msg, input int w, input logic [31:0] poly,
                                            input logic [31:0] init, input bit refin);
    logic [31:0] mask;
    logic [31:0] r;
    bit          bits[$];
    mask = (w == 32) ? 32'hFFFFFFFF : ((32'd1 << w) - 32'd1);
    r = init;
    foreach (msg[i]) for (int b = 0; b < 8; b++) bits.push_back(refin ? msg[i][b] : msg[i][7-b]);
    foreach (bits[j]) begin
      bit top;
      top = r[w-1] ^ bits[j];
      r = (r << 1) & mask;
      if (top) r = r ^ poly;
    end
    return r;
  endfunction

  function automatic exp_t model16(input bq_t msg);
    exp_t e;
    logic [31:0] r;
    r = model_reg(msg, 16, 32'h8005, 32'hFFFF, 1'b1);
    e.crc = reflect(r, 16) ^ 32'h0000FFFF;
    e.ok  = (r == 32'h800D);
    return e;
  endfunction

  function automatic exp_t model32(input bq_t msg);
    exp_t e;
    logic [31:0] r;
    r = model_reg(msg, 32, 32'h04C11DB7, 32'hFFFFFFFF, 1'b1);
    e.crc = reflect(r, 32) ^ 32'hFFFFFFFF;
    e.ok  = (r == 32'hC704DD7B);
    return e;
  endfunction

  function automatic vec_t mk(input bit v, input bit sop, input bit eop, input logic [7:0] d,
                              input bit cr, input bit ecv, input logic [15:0] eco, input bit eok);
    vec_t t;
    t.v = v; t.sop = sop; t.eop = eop; t.d = d; t.cr = cr;
    t.exp_cv = ecv; t.exp_co = eco; t.exp_ok = eok;
    return t;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Offer one beat and wait (bounded) for the handshake; returns just after the accepting edge.
  task automatic beat16(input logic [7:0] d, input bit sop, input bit eop);
    int budget;
    bit acc;
    budget = 0;
    v16 = 1'b1; d16 = d; sop16 = sop; eop16 = eop; nb16 = 1'b0;
    do begin
      @(negedge clk); acc = rdy16;
      @(posedge clk); #1;
      budget++;
    end while (!acc && budget < 200);
    if (!acc) chk("beat16_timeout", 32'd0, 32'd1);
    v16 = 1'b0; sop16 = 1'b0; eop16 = 1'b0;
  endtask

  task automatic beat32(input logic [31:0] d, input bit sop, input bit eop, input logic [2:0] nb);
    int budget;
    bit acc;
    budget = 0;
    v32 = 1'b1; d32 = d; sop32 = sop; eop32 = eop; nb32 = nb;
    do begin
      @(negedge clk); acc = rdy32;
      @(posedge clk); #1;
      budget++;
    end while (!acc && budget < 200);
    if (!acc) chk("beat32_timeout", 32'd0, 32'd1);
    v32 = 1'b0; sop32 = 1'b0; eop32 = 1'b0;
  endtask

  task automatic send16(input bq_t msg, input bit with_sop);
    foreach (msg[i]) beat16(msg[i], with_sop && (i == 0), i == msg.size() - 1);
  endtask

  // Scoreboards: results are checked when the handshake is seen, and held results must not move.
  bit   mon16_en = 1'b0, rand_cr16 = 1'b0, hold16_p = 1'b0;
  bit   mon32_en = 1'b0, rand_cr32 = 1'b0, hold32_p = 1'b0;
  logic [31:0] hold16_co, hold32_co;
  exp_t q16[$], q32[$];
  exp_t e16, e32;

  always @(posedge clk) if (rand_cr16) begin #1; cr16 = ($urandom_range(0, 3) != 0); end
  always @(posedge clk) if (rand_cr32) begin #1; cr32 = ($urandom_range(0, 3) != 0); end

  always @(negedge clk) begin
    if (mon16_en && !rst) begin
      chk("rdy16_rule", 32'(rdy16), 32'(!cv16 || cr16));
      if (hold16_p) begin
        chk("hold16_valid", 32'(cv16), 32'd1);
        chk("hold16_stable", 32'(co16), hold16_co);
      end
      if (cv16 && cr16) begin
        if (q16.size() == 0) chk("sb16_unexpected", 32'd1, 32'd0);
        else begin
          e16 = q16.pop_front();
          chk("sb16_crc", 32'(co16), e16.crc);
          chk("sb16_ok", 32'(ok16), 32'(e16.ok));
        end
      end
      hold16_p = cv16 && !cr16;
      hold16_co = 32'(co16);
    end else hold16_p = 1'b0;
  end

  always @(negedge clk) begin
    if (mon32_en && !rst) begin
      chk("rdy32_rule", 32'(rdy32), 32'(!cv32 || cr32));
      if (hold32_p) begin
        chk("hold32_valid", 32'(cv32), 32'd1);
        chk("hold32_stable", co32, hold32_co);
      end
      if (cv32 && cr32) begin
        if (q32.size() == 0) chk("sb32_unexpected", 32'd1, 32'd0);
        else begin
          e32 = q32.pop_front();
          chk("sb32_crc", co32, e32.crc);
          chk("sb32_ok", 32'(ok32), 32'(e32.ok));
        end
      end
      hold32_p = cv32 && !cr32;
      hold32_co = co32;
    end else hold32_p = 1'b0;
  end

  task automatic rand16(input int nframes);
    for (int f = 0; f < nframes; f++) begin
      bq_t  msg;
      exp_t e;
      bit   nosop;
      msg.delete();
      repeat ($urandom_range(1, 10)) msg.push_back(8'($urandom_range(0, 255)));
      if ($urandom_range(0, 4) == 0) begin
        e = model16(msg);
        msg.push_back(e.crc[7:0]);
        msg.push_back(e.crc[15:8]);
      end
      q16.push_back(model16(msg));
      nosop = ($urandom_range(0, 4) == 0);
      foreach (msg[i]) begin
        idle($urandom_range(0, 2));
        beat16(msg[i], !nosop && (i == 0), i == msg.size() - 1);
      end
    end
  endtask

  task automatic rand32(input int nframes);
    for (int f = 0; f < nframes; f++) begin
      bq_t         msg;
      exp_t        e;
      int          len, nbeats, rem;
      logic [31:0] d;
      logic [2:0]  nb;
      msg.delete();
      repeat ($urandom_range(1, 14)) msg.push_back(8'($urandom_range(0, 255)));
      if ($urandom_range(0, 4) == 0) begin
        e = model32(msg);
        for (int k = 0; k < 4; k++) msg.push_back(e.crc[8*k +: 8]);
      end
      q32.push_back(model32(msg));
      len = msg.size();
      nbeats = (len + 3) / 4;
      for (int b = 0; b < nbeats; b++) begin
        d = $urandom;
        for (int k = 0; k < 4; k++) if (4*b + k < len) d[8*k +: 8] = msg[4*b + k];
        rem = len - 4*b;
        if (b == nbeats - 1) nb = (rem == 4 && $urandom_range(0, 1) == 1) ? 3'd0 : 3'(rem);
        else nb = 3'($urandom_range(0, 7));
        idle($urandom_range(0, 2));
        beat32(d, b == 0, b == nbeats - 1, nb);
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bq_t  f1, f2, f3, m00, mff, m1234;
    vec_t tbl[$];
    exp_t ex;

    rst = 1'b1;
    v16 = 1'b0; d16 = '0; sop16 = 1'b0; eop16 = 1'b0; nb16 = '0; cr16 = 1'b1;
    v32 = 1'b0; d32 = '0; sop32 = 1'b0; eop32 = 1'b0; nb32 = '0; cr32 = 1'b1;
    f1 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    f2 = f1; f2.push_back(8'hC8); f2.push_back(8'hB4);
    m00 = '{8'h00}; mff = '{8'hFF}; m1234 = '{8'h31, 8'h32, 8'h33, 8'h34};

    idle(2);
    chk("rst16_valid", 32'(cv16), 32'd0);
    chk("rst16_out", 32'(co16), 32'd0);
    chk("rst16_ok", 32'(ok16), 32'd0);
    chk("rst16_ready", 32'(rdy16), 32'd1);
    chk("rst32_valid", 32'(cv32), 32'd0);
    chk("rst32_out", co32, 32'd0);
    rst = 1'b0;
    idle(1);

    // Table: "123456789", then with its CRC appended, then a sop-less frame with a gap.
    for (int i = 0; i < 9; i++)
      tbl.push_back(mk(1, i == 0, i == 8, f1[i], 1, i == 8, (i == 8) ? 16'hB4C8 : 16'h0000, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 0, 16'hB4C8, 0));
    for (int i = 0; i < 11; i++)
      tbl.push_back(mk(1, i == 0, i == 10, f2[i], 1, i == 10, (i == 10) ? 16'h4FFE : 16'hB4C8, i == 10));
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 0, 16'h4FFE, 1));
    for (int i = 0; i < 9; i++) begin
      tbl.push_back(mk(1, 0, i == 8, f1[i], 1, i == 8, (i == 8) ? 16'hB4C8 : 16'h4FFE, i != 8));
      if (i == 3) tbl.push_back(mk(0, 0, 0, 8'hEE, 1, 0, 16'h4FFE, 1));
    end
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 0, 16'hB4C8, 0));
    foreach (tbl[i]) begin
      v16 = tbl[i].v; sop16 = tbl[i].sop; eop16 = tbl[i].eop; d16 = tbl[i].d; cr16 = tbl[i].cr;
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_valid", i), 32'(cv16), 32'(tbl[i].exp_cv));
      chk($sformatf("tbl%0d_out", i), 32'(co16), 32'(tbl[i].exp_co));
      chk($sformatf("tbl%0d_ok", i), 32'(ok16), 32'(tbl[i].exp_ok));
    end
    v16 = 1'b0; sop16 = 1'b0; eop16 = 1'b0;

    // Backpressure: result held for 10 cycles, then a new beat is taken as the old one is consumed.
    cr16 = 1'b0;
    send16(f1, 1'b1);
    chk("bp_valid", 32'(cv16), 32'd1);
    chk("bp_out", 32'(co16), 32'h0000B4C8);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); chk("bp_in_ready_low", 32'(rdy16), 32'd0);
      @(posedge clk); #1;
      chk("bp_hold_out", 32'(co16), 32'h0000B4C8);
      chk("bp_hold_valid", 32'(cv16), 32'd1);
    end
    cr16 = 1'b1; v16 = 1'b1; d16 = 8'h00; sop16 = 1'b1; eop16 = 1'b1;
    @(negedge clk); chk("bp_in_ready_high", 32'(rdy16), 32'd1);
    @(posedge clk); #1;
    v16 = 1'b0; sop16 = 1'b0; eop16 = 1'b0;
    ex = model16(m00);
    chk("bp_next_valid", 32'(cv16), 32'd1);
    chk("bp_next_out", 32'(co16), ex.crc);
    idle(1);
    chk("bp_drop_valid", 32'(cv16), 32'd0);

    // Back-to-back single-beat frames.
    beat16(8'h00, 1'b1, 1'b1);
    ex = model16(m00);
    chk("b2b0_valid", 32'(cv16), 32'd1);
    chk("b2b0_out", 32'(co16), ex.crc);
    beat16(8'hFF, 1'b1, 1'b1);
    ex = model16(mff);
    chk("b2b1_valid", 32'(cv16), 32'd1);
    chk("b2b1_out", 32'(co16), ex.crc);
    idle(1);
    chk("b2b_end_valid", 32'(cv16), 32'd0);

    // A sop in RUN abandons the partial frame.
    beat16(8'h31, 1'b1, 1'b0); beat16(8'h32, 1'b0, 1'b0); beat16(8'h33, 1'b0, 1'b0);
    send16(f1, 1'b1);
    chk("restart_out", 32'(co16), 32'h0000B4C8);
    idle(1);

    // Reset mid-frame, then a full frame.
    for (int i = 0; i < 4; i++) beat16(f1[i], i == 0, 1'b0);
    rst = 1'b1;
    @(negedge clk); chk("rstmid_ready", 32'(rdy16), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstmid_valid", 32'(cv16), 32'd0);
    chk("rstmid_out", 32'(co16), 32'd0);
    send16(f1, 1'b1);
    chk("rstmid_final_valid", 32'(cv16), 32'd1);
    chk("rstmid_final_out", 32'(co16), 32'h0000B4C8);
    idle(1);

    // Reset while a result is held discards it.
    cr16 = 1'b0;
    beat16(8'h00, 1'b1, 1'b1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("rsthold_valid", 32'(cv16), 32'd0);
    chk("rsthold_out", 32'(co16), 32'd0);
    cr16 = 1'b1;
    idle(1);

    // CRC-32 word-wide: check value with partial last beat, residue frame, in_bytes 0 and 4.
    beat32(32'h34333231, 1'b1, 1'b0, 3'd5);
    beat32(32'h38373635, 1'b0, 1'b0, 3'd2);
    beat32(32'hA5A5A539, 1'b0, 1'b1, 3'd1);
    chk("c32_valid", 32'(cv32), 32'd1);
    chk("c32_out", co32, 32'hCBF43926);
    chk("c32_ok", 32'(ok32), 32'd0);
    beat32(32'h34333231, 1'b1, 1'b0, 3'd0);
    beat32(32'h38373635, 1'b0, 1'b0, 3'd0);
    beat32(32'hF4392639, 1'b0, 1'b0, 3'd3);
    beat32(32'h5A5A5ACB, 1'b0, 1'b1, 3'd1);
    chk("c32res_out", co32, 32'h2144DF1C);
    chk("c32res_ok", 32'(ok32), 32'd1);
    ex = model32(m1234);
    beat32(32'h34333231, 1'b1, 1'b1, 3'd0);
    chk("c32_nb0_out", co32, ex.crc);
    beat32(32'h34333231, 1'b1, 1'b1, 3'd4);
    chk("c32_nb4_out", co32, ex.crc);
    idle(1);
    chk("c32_end_valid", 32'(cv32), 32'd0);

    // Randomized frames with random gaps and consumer stalls.
    mon16_en = 1'b1; rand_cr16 = 1'b1;
    rand16(40);
    rand_cr16 = 1'b0; @(posedge clk); #2; cr16 = 1'b1;
    for (int i = 0; i < 50 && q16.size() != 0; i++) idle(1);
    chk("drain16", 32'(q16.size()), 32'd0);
    idle(2);
    mon16_en = 1'b0;

    mon32_en = 1'b1; rand_cr32 = 1'b1;
    rand32(40);
    rand_cr32 = 1'b0; @(posedge clk); #2; cr32 = 1'b1;
    for (int i = 0; i < 50 && q32.size() != 0; i++) idle(1);
    chk("drain32", 32'(q32.size()), 32'd0);
    idle(2);
    mon32_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
